// File: rtl/dmem_sized.sv
// Byte-addressed little-endian data memory with a valid/ready request port,
// a registered response, alignment/range checking and a post-reset init sequencer.
module dmem_sized #(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 256,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   init_idx, init_idx_nx;
    logic [31:0]        mem [DEPTH];

    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         lane;
    logic               out_of_range;
    logic               misaligned;
    logic               req_err;
    logic               accept;
    logic               wr_en;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [31:0]        init_val;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_data;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state    <= state_nx;
            init_idx <= init_idx_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        init_idx_nx = init_idx;
        req_ready   = 1'b0;
        case (state)
            ST_INIT: begin
                init_idx_nx = init_idx + IDX_W'(1);
                if (init_idx == IDX_W'(DEPTH - 1))
                    state_nx = ST_RUN;
            end
            ST_RUN:  req_ready = 1'b1;
            default: state_nx = ST_INIT;
        endcase
    end

    assign init_done = (state == ST_RUN);
    assign init_val  = (INIT_MODE == 1) ? 32'(init_idx) + 32'd1 : 32'd0;

    assign word_idx = req_addr[2 +: IDX_W];
    assign lane     = req_addr[1:0];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_range
            assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    assign req_err = misaligned | out_of_range;
    assign accept  = req_valid & req_ready;
    assign wr_en   = accept & req_we & ~req_err;

    // Narrow stores replicate the data across the word; byte enables pick the lanes.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
        case (req_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset; the INIT sequence rewrites every word instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_idx] <= init_val;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b])
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    assign rd_word = mem[word_idx];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        case (req_size)
            2'b00:   load_data = {{24{req_signed & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{req_signed & rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            err_count <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & req_err;
            rsp_rdata <= (accept && !req_err && !req_we) ? load_data : 32'd0;
            if (accept && req_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
